mips_mem_responder: RTL and testbench
=====================================

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait states between request acceptance and response (0..15).
REQ-003 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  1  initiator requests an access; sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  32  byte address, word-aligned; sampled with req.
REQ-008 SHALL have port wdata  input  32  write data; sampled with req.
REQ-009 SHALL have port rdata  output  32  read data; valid only while ready=1.
REQ-010 SHALL have port ready  output  1  one-cycle pulse that completes the accepted access.
REQ-011 SHALL have port busy  output  1  high from the cycle after acceptance through the ready cycle.
REQ-012 SHALL have port err  output  1  misaligned-access flag; valid only while ready=1.

Function
REQ-013 SHALL implement the states IDLE, WAIT and RESP.
REQ-014 SHALL accept a request on a rising edge where state=IDLE and req=1, latching we, addr and wdata on that edge.
REQ-015 SHALL, on acceptance, load a 4-bit wait counter with WAIT_CYCLES and enter WAIT; if WAIT_CYCLES=0, it SHALL enter RESP directly.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the edge where the counter reads 1.
REQ-017 SHALL hold ready=1 for exactly the one cycle spent in RESP, then return to IDLE.
REQ-018 SHALL complete an access with ready on cycle WAIT_CYCLES+1 after the accepting edge.
REQ-019 SHALL, for a read, drive rdata with the word at index addr[log2(DEPTH_WORDS)+1:2] during RESP.
REQ-020 SHALL, for a write, update that word on the edge that leaves RESP, so a following read returns the new data.
REQ-021 SHALL wrap addresses above the memory range modulo DEPTH_WORDS; higher address bits are ignored.
REQ-022 SHALL treat addr[1:0]!=0 as misaligned: err=1 with ready, no memory write, rdata=0.
REQ-023 SHALL ignore req, we, addr and wdata while in WAIT or RESP; latched values govern the access.
REQ-024 SHALL allow the next acceptance no earlier than the cycle after RESP (back-to-back throughput of one access per WAIT_CYCLES+2 cycles).
REQ-025 SHALL drive rdata=0 and err=0 whenever ready=0.
REQ-026 SHALL register all outputs; no output depends combinationally on inputs.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, enter IDLE, clear the counter, and drive ready=0, busy=0, err=0, rdata=0.
REQ-028 SHALL abort any in-flight access on reset without writing memory; a req arriving with reset is not accepted.
REQ-029 SHALL leave memory contents unchanged by reset; initial contents are undefined unless preloaded by the bench.

Structure
REQ-030 SHALL take the state encoding (IDLE=0, WAIT=1, RESP=2) and the word-size constant from the shared CPU package, which also holds the LW/SW/BEQ/J opcode constants.
REQ-031 SHALL place the storage array in a sub-module named word_ram (synchronous write, registered read, DEPTH_WORDS parameter); the FSM and counter stay in the top.

Verification
REQ-032 SHALL cover this scenario: WAIT_CYCLES=2; write 0xDEADBEEF to 0x10, then read 0x10 -> ready pulses 3 cycles after each accept; read returns rdata=0xDEADBEEF, err=0.
REQ-033 SHALL cover this scenario: WAIT_CYCLES=0; read 0x0 then 0x4 with req held high -> ready pulses on cycles 1 and 3 and busy never exceeds 1 cycle per access.
REQ-034 SHALL cover this scenario: write 0x12345678 to 0x1002 (misaligned) -> err=1, rdata=0; a subsequent read of 0x1000 returns the prior contents.
REQ-035 SHALL cover this scenario: DEPTH_WORDS=1024; write 0xA5A5A5A5 to 0x1000 -> a read of 0x0000 returns 0xA5A5A5A5 (wrap).
REQ-036 SHALL cover this scenario: accept a write of 0xFFFFFFFF to 0x20, assert reset during WAIT -> no ready pulse; after reset, a read of 0x20 returns the pre-write value.
REQ-037 SHALL cover this scenario: change addr and wdata during WAIT -> the completed access uses the values latched at acceptance.

Source files
------------

// File: rtl/mips_mem_responder_pkg.sv
// Shared CPU package: FSM state encoding, word-size constants, opcodes and
// small address helpers used by the memory responder.
package mips_mem_responder_pkg;

  localparam int WORD_BITS  = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  function automatic logic is_misaligned(input logic [WORD_BITS-1:0] a);
    return (a[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// Initiator/responder bus of the memory responder; master = CPU side,
// slave = memory side.
interface mips_mem_responder_if;
  import mips_mem_responder_pkg::*;

  logic                 req;
  logic                 we;
  logic [WORD_BITS-1:0] addr;
  logic [WORD_BITS-1:0] wdata;
  logic [WORD_BITS-1:0] rdata;
  logic                 ready;
  logic                 busy;
  logic                 err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/mips_mem_responder_word_ram.sv
// Word-addressed storage: synchronous write, registered read whose output
// returns to zero on any cycle without a read strobe.
module word_ram
  import mips_mem_responder_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem_r [DEPTH_WORDS];

  // Array write port and zero-when-idle registered read port.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_r[raddr];
    end else begin
      rdata <= {WORD_BITS{1'b0}};
    end
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Wait-state memory responder: accepts one access in IDLE, counts wait
// states, then pulses ready for one cycle with read data or a misalign flag.
module mips_mem_responder
  import mips_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  mips_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t               state_r;
  logic [3:0]           cnt_r;
  logic                 we_r;
  logic                 mis_r;
  logic [AW-1:0]        idx_r;
  logic [WORD_BITS-1:0] wdata_r;
  logic                 ready_r;
  logic                 busy_r;
  logic                 err_r;

  logic                 resp_next_s;
  logic                 acc_we_s;
  logic                 acc_mis_s;
  logic [AW-1:0]        acc_idx_s;
  logic                 ram_re_s;
  logic                 ram_we_s;
  logic [WORD_BITS-1:0] ram_rdata_s;
  logic                 unused_addr_s;

  // Address bits above the memory range alias onto the same words.
  assign unused_addr_s = ^bus.addr[WORD_BITS-1:AW+2];

  // In IDLE the incoming request is the access; afterwards the latched copy is.
  always_comb begin
    acc_we_s    = 1'b0;
    acc_mis_s   = 1'b0;
    acc_idx_s   = '0;
    resp_next_s = 1'b0;
    if (state_r == IDLE) begin
      acc_we_s    = bus.we;
      acc_mis_s   = is_misaligned(bus.addr);
      acc_idx_s   = bus.addr[AW+1:2];
      resp_next_s = !reset && bus.req && (WAIT_CYCLES == 0);
    end else begin
      acc_we_s    = we_r;
      acc_mis_s   = mis_r;
      acc_idx_s   = idx_r;
      resp_next_s = !reset && (state_r == WAIT) && (cnt_r <= 4'd1);
    end
    ram_re_s = resp_next_s && !acc_we_s && !acc_mis_s;
    ram_we_s = !reset && (state_r == RESP) && we_r && !mis_r;
  end

  // Access sequencer with registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      mis_r   <= 1'b0;
      idx_r   <= '0;
      wdata_r <= {WORD_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= resp_next_s;
          err_r   <= resp_next_s && acc_mis_s;
          busy_r  <= bus.req;
          if (bus.req) begin
            we_r    <= bus.we;
            mis_r   <= acc_mis_s;
            idx_r   <= acc_idx_s;
            wdata_r <= bus.wdata;
            cnt_r   <= resp_next_s ? 4'd0 : 4'(WAIT_CYCLES);
            state_r <= resp_next_s ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (resp_next_s) begin
            state_r <= RESP;
            ready_r <= 1'b1;
            err_r   <= mis_r;
          end
        end
        RESP: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_word_ram (
    .clock (clock),
    .we    (ram_we_s),
    .waddr (idx_r),
    .wdata (wdata_r),
    .re    (ram_re_s),
    .raddr (acc_idx_s),
    .rdata (ram_rdata_s)
  );

  assign bus.rdata = ram_rdata_s;
  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.err   = err_r;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Scoreboard bench: two responders (2 wait states and 0 wait states) driven by
// directed and random accesses, checked against a word-array reference model.
module tb_mips_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WA    = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mips_mem_responder_if bus_a();
  mips_mem_responder_if bus_b();

  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WA)) dut_a (
    .clock (clock), .reset (reset), .bus (bus_a.slave));
  mips_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clock (clock), .reset (reset), .bus (bus_b.slave));

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    bit          care;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] model [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: words indexed by (addr / 4) mod DEPTH; ready in cycle W+1 after accept.
  function automatic exp_t predict(input bit we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int acc_cyc);
    exp_t e;
    int   idx;
    idx    = int'((addr / 4) % DEPTH);
    e.cyc  = acc_cyc + WA;
    e.rdata = 32'd0;
    e.err  = 1'b0;
    e.care = 1'b1;
    if (addr % 4 != 0) begin
      e.err = 1'b1;
    end else if (we) begin
      model[idx] = wdata;
    end else if (model.exists(idx)) begin
      e.rdata = model[idx];
    end else begin
      e.care = 1'b0;
    end
    return e;
  endfunction

  task automatic op_a(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit seen;
    @(negedge clock);
    check("a_busy_before_accept", {31'd0, bus_a.busy}, 32'd0);
    bus_a.req = 1'b1; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata;
    @(posedge clock); #1;
    q_a.push_back(predict(we, addr, wdata, cyc));
    seen = 1'b0;
    for (int i = 0; i < WA + 6; i++) begin
      @(negedge clock);
      if (i == 0) check("a_busy_after_accept", {31'd0, bus_a.busy}, 32'd1);
      if (bus_a.ready) begin
        seen = 1'b1;
        bus_a.req = 1'b0;
        break;
      end
      // Inputs outside IDLE must be ignored.
      bus_a.req = 1'($urandom); bus_a.we = 1'($urandom);
      bus_a.addr = $urandom; bus_a.wdata = $urandom;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL a_ready_timeout: got no ready, expected ready for addr %h", addr);
      bus_a.req = 1'b0;
    end
  endtask

  task automatic op_abort_a(input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clock);
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = addr; bus_a.wdata = wdata;
    @(posedge clock); #1;
    @(negedge clock);
    bus_a.req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("a_busy_after_abort", {31'd0, bus_a.busy}, 32'd0);
    check("a_ready_after_abort", {31'd0, bus_a.ready}, 32'd0);
    repeat (WA + 3) @(negedge clock);
  endtask

  // Monitor A: ready must appear exactly when the scoreboard head is due.
  always @(negedge clock) begin
    exp_t e;
    bit   due;
    if (!reset) begin
      due = (q_a.size() > 0) && (q_a[0].cyc == cyc);
      check("a_ready_timing", {31'd0, bus_a.ready}, {31'd0, due});
      if (due) begin
        e = q_a.pop_front();
        check("a_err", {31'd0, bus_a.err}, {31'd0, e.err});
        check("a_busy_at_ready", {31'd0, bus_a.busy}, 32'd1);
        if (e.care) check("a_rdata", bus_a.rdata, e.rdata);
      end else begin
        check("a_quiet_outputs", bus_a.rdata | {31'd0, bus_a.err}, 32'd0);
      end
    end
  end

  // Monitor B: zero wait states, so busy and ready are the same single cycle.
  always @(negedge clock) begin
    exp_t e;
    bit   due;
    if (!reset) begin
      due = (q_b.size() > 0) && (q_b[0].cyc == cyc);
      check("b_ready_timing", {31'd0, bus_b.ready}, {31'd0, due});
      check("b_busy", {31'd0, bus_b.busy}, {31'd0, due});
      if (due) begin
        e = q_b.pop_front();
        check("b_err", {31'd0, bus_b.err}, {31'd0, e.err});
        check("b_rdata", bus_b.rdata, e.rdata);
      end else begin
        check("b_quiet_outputs", bus_b.rdata | {31'd0, bus_b.err}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] b_addr  [4];
    logic [31:0] b_wdata [4];
    logic [31:0] b_exp   [4];
    bit          b_we    [4];
    bit          seen;
    int          first;
    logic [31:0] a;

    b_we = '{1'b1, 1'b1, 1'b0, 1'b0};
    b_addr = '{32'h0, 32'h4, 32'h0, 32'h4};
    b_wdata = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
    b_exp = '{32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222};

    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = 32'd0; bus_a.wdata = 32'd0;
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = 32'd0; bus_b.wdata = 32'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset_ready", {31'd0, bus_a.ready}, 32'd0);
    check("reset_busy", {31'd0, bus_a.busy}, 32'd0);
    check("reset_rdata", bus_a.rdata, 32'd0);
    check("reset_err", {31'd0, bus_b.err}, 32'd0);

    // Zero-wait responder with req held high across four accesses.
    bus_b.req = 1'b1; bus_b.we = b_we[0]; bus_b.addr = b_addr[0]; bus_b.wdata = b_wdata[0];
    @(posedge clock); #1;
    first = cyc;
    for (int k = 0; k < 4; k++) q_b.push_back('{first + 2 * k, b_exp[k], 1'b0, 1'b1});
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clock);
        if (bus_b.ready) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL b_ready_timeout: got no ready, expected access %0d", k);
      end
      if (k < 3) begin
        bus_b.we = b_we[k+1]; bus_b.addr = b_addr[k+1]; bus_b.wdata = b_wdata[k+1];
      end else begin
        bus_b.req = 1'b0;
      end
    end
    repeat (3) @(negedge clock);

    // Directed accesses on the two-wait-state responder.
    op_a(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    op_a(1'b0, 32'h0000_0010, 32'h0);
    op_a(1'b1, 32'h0000_1000, 32'h1357_2468);
    op_a(1'b1, 32'h0000_1002, 32'h1234_5678);
    op_a(1'b0, 32'h0000_1000, 32'h0);
    op_a(1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
    op_a(1'b0, 32'h0000_0000, 32'h0);
    op_a(1'b1, 32'h0000_0020, 32'h600D_CAFE);
    op_abort_a(32'h0000_0020, 32'hFFFF_FFFF);
    op_a(1'b0, 32'h0000_0020, 32'h0);

    // A request coincident with reset is not accepted.
    @(negedge clock);
    reset = 1'b1;
    bus_a.req = 1'b1; bus_a.we = 1'b1; bus_a.addr = 32'h0000_0010; bus_a.wdata = 32'h0BAD_0BAD;
    @(negedge clock);
    bus_a.req = 1'b0;
    reset = 1'b0;
    check("a_req_with_reset_busy", {31'd0, bus_a.busy}, 32'd0);
    op_a(1'b0, 32'h0000_0010, 32'h0);

    // Random mix of reads, writes, misaligned and aliased addresses.
    for (int n = 0; n < 80; n++) begin
      a = 32'($urandom_range(0, 31)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      op_a(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (WA + 4) @(negedge clock);
    check("a_pending_at_end", 32'(q_a.size()), 32'd0);
    check("b_pending_at_end", 32'(q_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
